// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with EX-stage operand forwarding
// and ALU operand select for the RV32I pipeline.
//
// Ports:
//   clock, reset_n            rising-edge clock, async active-low reset
//   id_*                      decoded instruction fields presented by ID
//   mem_reg_write/rd/result   MEM-stage writeback, forwarding source (priority)
//   wb_reg_write/rd/result    WB-stage writeback, forwarding source
//   ext_stall                 downstream stall: hold the EX register
//   flush                     branch/jump kill: bubble the EX register
//   hazard_stall              load-use stall request to IF/ID
//   ex_valid, ex_pc, ex_rd    registered instruction state
//   ex_reg_write/mem_read/mem_write  registered controls, gated by ex_valid
//   alu_d1, alu_d2, alu_choice       ALU operands and op code
//   ex_store_data             forwarded rs2 value for stores
module ex_operand_stage #(
  parameter int BW = 32,
  parameter int RW = 5
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          id_valid,
  input  logic [BW-1:0] id_pc,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic [RW-1:0] id_rd,
  input  logic [BW-1:0] id_rs1_data,
  input  logic [BW-1:0] id_rs2_data,
  input  logic [BW-1:0] id_imm,
  input  logic [3:0]    id_alu_op,
  input  logic [1:0]    id_src1_sel,
  input  logic [1:0]    id_src2_sel,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          mem_reg_write,
  input  logic [RW-1:0] mem_rd,
  input  logic [BW-1:0] mem_result,
  input  logic          wb_reg_write,
  input  logic [RW-1:0] wb_rd,
  input  logic [BW-1:0] wb_result,
  input  logic          ext_stall,
  input  logic          flush,
  output logic          hazard_stall,
  output logic          ex_valid,
  output logic [BW-1:0] ex_pc,
  output logic [RW-1:0] ex_rd,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic [BW-1:0] alu_d1,
  output logic [BW-1:0] alu_d2,
  output logic [3:0]    alu_choice,
  output logic [BW-1:0] ex_store_data
);

  typedef enum logic [1:0] {
    SRC1_RS1  = 2'd0,
    SRC1_PC   = 2'd1,
    SRC1_ZERO = 2'd2,
    SRC1_RSV  = 2'd3
  } src1_e;

  typedef enum logic [1:0] {
    SRC2_RS2  = 2'd0,
    SRC2_IMM  = 2'd1,
    SRC2_FOUR = 2'd2,
    SRC2_RSV  = 2'd3
  } src2_e;

  // Control group (cleared by bubbles)
  logic          valid_q, valid_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [3:0]    alu_op_q, alu_op_d;

  // Datapath group (only reloaded on a real capture)
  logic [BW-1:0] pc_q;
  logic [RW-1:0] rs1_q, rs2_q, rd_q;
  logic [BW-1:0] rs1_data_q, rs2_data_q, imm_q;
  src1_e         src1_sel_q;
  src2_e         src2_sel_q;

  logic          hazard;
  logic          load;
  logic [BW-1:0] fwd_rs1, fwd_rs2;

  // Load-use: the load in EX has not produced data yet, so ID must wait one
  // cycle. A flush kills the ID instruction anyway, so no stall is needed.
  assign hazard = valid_q & mem_read_q & id_valid & (rd_q != '0) &
                  ((rd_q == id_rs1) | (rd_q == id_rs2)) & ~flush;
  assign hazard_stall = hazard;

  assign load = ~flush & ~ext_stall & ~hazard;

  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    alu_op_d    = alu_op_q;
    if (flush || (!ext_stall && hazard)) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      alu_op_d    = '0;
    end else if (!ext_stall) begin
      valid_d     = id_valid;
      reg_write_d = id_reg_write & id_valid;
      mem_read_d  = id_mem_read  & id_valid;
      mem_write_d = id_mem_write & id_valid;
      alu_op_d    = id_alu_op;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_op_q    <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      alu_op_q    <= alu_op_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      src1_sel_q <= SRC1_RS1;
      src2_sel_q <= SRC2_RS2;
    end else if (load) begin
      pc_q       <= id_pc;
      rs1_q      <= id_rs1;
      rs2_q      <= id_rs2;
      rd_q       <= id_rd;
      rs1_data_q <= id_rs1_data;
      rs2_data_q <= id_rs2_data;
      imm_q      <= id_imm;
      src1_sel_q <= src1_e'(id_src1_sel);
      src2_sel_q <= src2_e'(id_src2_sel);
    end
  end

  // Forwarding: MEM is younger than WB, so it wins; x0 is never forwarded.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs1_q))
      fwd_rs1 = mem_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs1_q))
      fwd_rs1 = wb_result;
  end

  always_comb begin
    fwd_rs2 = rs2_data_q;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs2_q))
      fwd_rs2 = mem_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs2_q))
      fwd_rs2 = wb_result;
  end

  always_comb begin
    alu_d1 = '0;
    unique case (src1_sel_q)
      SRC1_RS1:  alu_d1 = fwd_rs1;
      SRC1_PC:   alu_d1 = pc_q;
      SRC1_ZERO: alu_d1 = '0;
      SRC1_RSV:  alu_d1 = '0;
    endcase
  end

  always_comb begin
    alu_d2 = '0;
    unique case (src2_sel_q)
      SRC2_RS2:  alu_d2 = fwd_rs2;
      SRC2_IMM:  alu_d2 = imm_q;
      SRC2_FOUR: alu_d2 = BW'(4);
      SRC2_RSV:  alu_d2 = '0;
    endcase
  end

  assign ex_store_data = fwd_rs2;
  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = reg_write_q & valid_q;
  assign ex_mem_read   = mem_read_q  & valid_q;
  assign ex_mem_write  = mem_write_q & valid_q;
  assign alu_choice    = alu_op_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

  localparam int BW = 32;
  localparam int RW = 5;
  localparam logic [3:0] ALU_ADD = 4'd0;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          id_valid;
  logic [BW-1:0] id_pc;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic [BW-1:0] id_rs1_data, id_rs2_data, id_imm;
  logic [3:0]    id_alu_op;
  logic [1:0]    id_src1_sel, id_src2_sel;
  logic          id_reg_write, id_mem_read, id_mem_write;
  logic          mem_reg_write;
  logic [RW-1:0] mem_rd;
  logic [BW-1:0] mem_result;
  logic          wb_reg_write;
  logic [RW-1:0] wb_rd;
  logic [BW-1:0] wb_result;
  logic          ext_stall, flush;
  logic          hazard_stall, ex_valid;
  logic [BW-1:0] ex_pc;
  logic [RW-1:0] ex_rd;
  logic          ex_reg_write, ex_mem_read, ex_mem_write;
  logic [BW-1:0] alu_d1, alu_d2, ex_store_data;
  logic [3:0]    alu_choice;

  int n_cmp = 0;
  int n_bad = 0;

  always #10 clock = ~clock;

  ex_operand_stage #(.BW(BW), .RW(RW)) dut (
    .clock(clock), .reset_n(reset_n),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_src1_sel(id_src1_sel), .id_src2_sel(id_src2_sel),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .ext_stall(ext_stall), .flush(flush),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .alu_d1(alu_d1), .alu_d2(alu_d2), .alu_choice(alu_choice),
    .ex_store_data(ex_store_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model: the instruction sitting in EX -------
  typedef struct {
    bit          v;
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic [1:0]  s1, s2;
    bit          rw, mr, mw;
  } ex_t;

  ex_t m;

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] regv);
    if (mem_reg_write && mem_rd != 0 && mem_rd == r) return mem_result;
    if (wb_reg_write && wb_rd != 0 && wb_rd == r) return wb_result;
    return regv;
  endfunction

  function automatic bit model_hazard();
    return m.v && m.mr && id_valid && m.rd != 0 &&
           (m.rd == id_rs1 || m.rd == id_rs2) && !flush;
  endfunction

  function automatic logic [31:0] model_d1();
    case (m.s1)
      2'd0:    return fwd(m.rs1, m.rs1v);
      2'd1:    return m.pc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_d2();
    case (m.s2)
      2'd0:    return fwd(m.rs2, m.rs2v);
      2'd1:    return m.imm;
      2'd2:    return 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  function automatic ex_t empty_ex();
    ex_t e;
    e = '{v: 0, pc: 0, rs1v: 0, rs2v: 0, imm: 0, rs1: 0, rs2: 0, rd: 0,
          op: 0, s1: 0, s2: 0, rw: 0, mr: 0, mw: 0};
    return e;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m = empty_ex();
    end else if (flush || (!ext_stall && model_hazard())) begin
      m.v = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.op = 0;
    end else if (!ext_stall) begin
      m.v = id_valid;
      m.pc = id_pc; m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
      m.rs1v = id_rs1_data; m.rs2v = id_rs2_data; m.imm = id_imm;
      m.op = id_alu_op; m.s1 = id_src1_sel; m.s2 = id_src2_sel;
      m.rw = id_reg_write && id_valid;
      m.mr = id_mem_read && id_valid;
      m.mw = id_mem_write && id_valid;
    end
  end

  // Compare once per cycle, 1 time unit after the negedge input update.
  always @(negedge clock) begin
    #1;
    chk("ex_valid", 32'(ex_valid), 32'(m.v));
    chk("hazard_stall", 32'(hazard_stall), 32'(model_hazard()));
    chk("ex_reg_write", 32'(ex_reg_write), 32'(m.v && m.rw));
    chk("ex_mem_read", 32'(ex_mem_read), 32'(m.v && m.mr));
    chk("ex_mem_write", 32'(ex_mem_write), 32'(m.v && m.mw));
    chk("alu_choice", 32'(alu_choice), 32'(m.op));
    if (m.v) begin
      chk("ex_pc", ex_pc, m.pc);
      chk("ex_rd", 32'(ex_rd), 32'(m.rd));
      chk("alu_d1", alu_d1, model_d1());
      chk("alu_d2", alu_d2, model_d2());
      chk("ex_store_data", ex_store_data, fwd(m.rs2, m.rs2v));
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic idle_inputs();
    id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_op = 0;
    id_src1_sel = 0; id_src2_sel = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    mem_reg_write = 0; mem_rd = 0; mem_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
    ext_stall = 0; flush = 0;
  endtask

  task automatic present(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [3:0] op,
                         input logic [1:0] s1, input logic [1:0] s2,
                         input bit rw, input bit mr, input bit mw);
    id_valid = 1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_op = op;
    id_src1_sel = s1; id_src2_sel = s2;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  initial begin
    reset_n = 0;
    idle_inputs();
    #25 reset_n = 1;
    @(negedge clock); #2;
    chk("reset ex_valid", 32'(ex_valid), 0);
    chk("reset alu_choice", 32'(alu_choice), 0);
    chk("reset alu_d1", alu_d1, 0);
    chk("reset alu_d2", alu_d2, 0);
    chk("reset ex_reg_write", 32'(ex_reg_write), 0);

    // back-to-back dependency: addi x1,x0,5 ; add x2,x1,x1
    present(32'h10, 0, 0, 1, 0, 0, 5, ALU_ADD, 2'd0, 2'd1, 1, 0, 0);
    @(negedge clock);
    present(32'h14, 1, 1, 2, 0, 0, 0, ALU_ADD, 2'd0, 2'd0, 1, 0, 0);
    #2;
    chk("addi d1", alu_d1, 0);
    chk("addi d2", alu_d2, 5);
    @(negedge clock);
    id_valid = 0;
    mem_reg_write = 1; mem_rd = 1; mem_result = 5;
    #2;
    chk("b2b d1", alu_d1, 5);
    chk("b2b d2", alu_d2, 5);
    chk("b2b choice", 32'(alu_choice), 32'(ALU_ADD));
    chk("b2b valid", 32'(ex_valid), 1);
    chk("b2b stall", 32'(hazard_stall), 0);

    // MEM/WB conflict
    mem_reg_write = 0;
    present(32'h18, 3, 0, 4, 32'h1111, 0, 0, 4'd2, 2'd0, 2'd0, 1, 0, 0);
    @(negedge clock);
    idle_inputs();
    mem_reg_write = 1; mem_rd = 3; mem_result = 32'hAAAA;
    wb_reg_write = 1; wb_rd = 3; wb_result = 32'h5555;
    #2 chk("mem over wb", alu_d1, 32'hAAAA);
    #1 mem_reg_write = 0;
    #1 chk("wb only", alu_d1, 32'h5555);
    #1 wb_reg_write = 0;
    #1 chk("no fwd", alu_d1, 32'h1111);

    // x0 guard
    present(32'h1C, 0, 0, 5, 0, 0, 0, 4'd3, 2'd0, 2'd0, 1, 0, 0);
    @(negedge clock);
    idle_inputs();
    mem_reg_write = 1; mem_rd = 0; mem_result = 32'hDEAD;
    wb_reg_write = 1; wb_rd = 0; wb_result = 32'hBEEF;
    #2 chk("x0 d1", alu_d1, 0);
    chk("x0 store", ex_store_data, 0);

    // load-use: lw x5 ; add x6,x1,x5
    idle_inputs();
    present(32'h20, 2, 0, 5, 32'h40, 0, 8, ALU_ADD, 2'd0, 2'd1, 1, 1, 0);
    @(negedge clock);
    present(32'h24, 1, 5, 6, 32'h10, 32'h0, 0, ALU_ADD, 2'd0, 2'd0, 1, 0, 0);
    #2 chk("lu stall", 32'(hazard_stall), 1);
    chk("lu lw valid", 32'(ex_valid), 1);
    @(negedge clock);
    #2 chk("lu stall off", 32'(hazard_stall), 0);
    chk("lu bubble valid", 32'(ex_valid), 0);
    chk("lu bubble choice", 32'(alu_choice), 0);
    chk("lu bubble rw", 32'(ex_reg_write), 0);
    @(negedge clock);
    id_valid = 0;
    mem_reg_write = 1; mem_rd = 5; mem_result = 32'h1234;
    #2 chk("lu dep valid", 32'(ex_valid), 1);
    chk("lu dep d1", alu_d1, 32'h10);
    chk("lu dep d2", alu_d2, 32'h1234);
    chk("lu dep store", ex_store_data, 32'h1234);

    // flush beats stall and hazard
    idle_inputs();
    present(32'h30, 0, 0, 7, 0, 0, 0, ALU_ADD, 2'd0, 2'd1, 1, 1, 0);
    @(negedge clock);
    present(32'h34, 7, 0, 8, 0, 0, 0, ALU_ADD, 2'd0, 2'd0, 1, 0, 0);
    flush = 1; ext_stall = 1;
    #2 chk("flush stall", 32'(hazard_stall), 0);
    @(negedge clock);
    idle_inputs();
    #2 chk("flush valid", 32'(ex_valid), 0);
    chk("flush memrd", 32'(ex_mem_read), 0);

    // ext_stall holds for 3 cycles
    present(32'h100, 1, 2, 3, 1, 2, 3, 4'd4, 2'd1, 2'd2, 1, 0, 0);
    @(negedge clock);
    present(32'h200, 1, 2, 3, 1, 2, 3, 4'd4, 2'd1, 2'd2, 1, 0, 0);
    ext_stall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #2 chk("stall hold pc", ex_pc, 32'h100);
      chk("stall hold d2", alu_d2, 4);
    end
    ext_stall = 0;
    @(negedge clock);
    #2 chk("stall release pc", ex_pc, 32'h200);

    // async reset between edges
    present(32'h300, 1, 2, 3, 0, 0, 0, 4'd5, 2'd0, 2'd0, 1, 0, 0);
    @(negedge clock);
    #2 chk("pre-reset valid", 32'(ex_valid), 1);
    #1 reset_n = 0;
    #1 chk("areset valid", 32'(ex_valid), 0);
    chk("areset rw", 32'(ex_reg_write), 0);
    chk("areset choice", 32'(alu_choice), 0);
    idle_inputs();
    #2 reset_n = 1;
    @(negedge clock);
    #2 chk("post-reset valid", 32'(ex_valid), 0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      id_valid      = ($urandom_range(0, 3) != 0);
      id_pc         = $urandom;
      id_rs1        = 5'($urandom_range(0, 7));
      id_rs2        = 5'($urandom_range(0, 7));
      id_rd         = 5'($urandom_range(0, 7));
      id_rs1_data   = $urandom;
      id_rs2_data   = $urandom;
      id_imm        = $urandom;
      id_alu_op     = 4'($urandom);
      id_src1_sel   = 2'($urandom);
      id_src2_sel   = 2'($urandom);
      id_reg_write  = 1'($urandom);
      id_mem_read   = ($urandom_range(0, 2) == 0);
      id_mem_write  = ($urandom_range(0, 3) == 0);
      mem_reg_write = 1'($urandom);
      mem_rd        = 5'($urandom_range(0, 7));
      mem_result    = $urandom;
      wb_reg_write  = 1'($urandom);
      wb_rd         = 5'($urandom_range(0, 7));
      wb_result     = $urandom;
      ext_stall     = ($urandom_range(0, 7) == 0);
      flush         = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #3 reset_n = 0;
        #3 reset_n = 1;
      end
    end

    @(negedge clock);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
